cvt_token_sched: RTL and testbench

Sequencer and arbiter in front of the CVU_CVT convergence unit. It drives the CVT's 24-bit input token, first streaming a configuration phase, then round-robin sharing the CVT among NUM_REQ branch-token requesters. It keeps at most one control token outstanding, waiting for the CVT's send_batch. It ends the run on threads_terminated.

---
 rtl/cvt_token_sched.sv | 159 +++++++++++++++
 tb/tb_cvt_token_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvt_token_sched.sv
// Token sequencer/arbiter in front of the CVT: streams config beats, then round-robin branch tokens.
// Optional send_batch watchdog enabled by defining CVT_TIMEOUT_EN.
module cvt_token_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [9:0]                 cfg_data,
    input  logic                       cfg_last,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*5-1:0]       req_bb1,
    input  logic [NUM_REQ*5-1:0]       req_bb2,
    input  logic [NUM_REQ*10-1:0]      req_tbuf,
    input  logic [NUM_REQ-1:0]         req_force,
    output logic [23:0]                cvt_token,
    input  logic                       cvt_send_batch,
    input  logic                       cvt_threads_terminated,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {StIdle, StCfg, StArb, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, gid_q;
    logic [23:0]    token_q, token_d;
    logic           win_found, grant, tmo_hit;
    logic [IdW-1:0] win_idx;
    logic [4:0]     win_bb1, win_bb2;
    logic [9:0]     win_tbuf;
    logic           win_force;

    // Round-robin search starting just after the last winner.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_bb1   = '0;
        win_bb2   = '0;
        win_tbuf  = '0;
        win_force = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IdW'(cand);
                win_bb1   = req_bb1[5*cand +: 5];
                win_bb2   = req_bb2[5*cand +: 5];
                win_tbuf  = req_tbuf[10*cand +: 10];
                win_force = req_force[cand];
            end
        end
    end

    // Termination pre-empts any grant in the same cycle.
    assign grant = (state_q == StArb) && !cvt_threads_terminated && win_found;

`ifdef CVT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            err_q;

    assign tmo_hit = (state_q == StWait) && !cvt_send_batch && !cvt_threads_terminated &&
                     (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant) begin
                wait_cnt_q <= '0;
            end else if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= IdW'(NUM_REQ - 1);
            gid_q   <= '0;
            token_q <= '0;
        end else begin
            state_q <= state_d;
            token_q <= token_d;
            if (grant) begin
                ptr_q <= win_idx;
                gid_q <= win_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCfg;
            StCfg:  if (cfg_valid && cfg_last) state_d = StArb;
            StArb: begin
                if (cvt_threads_terminated) state_d = StDone;
                else if (grant)             state_d = StWait;
            end
            StWait: begin
                if (cvt_threads_terminated) state_d = StDone;
                else if (cvt_send_batch)    state_d = StArb;
                else if (tmo_hit)           state_d = StArb;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == StCfg);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Token fields: {force, tbuf, bb2, bb1, token_valid, ctrl, config}.
    always_comb begin
        token_d = '0;
        if (state_q == StCfg && cfg_valid) begin
            token_d = {1'b0, cfg_data, 5'd0, 5'd0, 3'b101};
        end else if (grant) begin
            token_d = {win_force, win_tbuf, win_bb2, win_bb1, 3'b110};
        end
    end

    assign cvt_token = token_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_cvt_token_sched.sv
// Randomized and directed bench for cvt_token_sched against a cycle-level behavioural model.
// Honours CVT_TIMEOUT_EN for the watchdog model (TIMEOUT fixed at 8 here).
module tb_cvt_token_sched;

    localparam int NREQ       = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int P_IDLE = 0, P_CFG = 1, P_ARB = 2, P_WAIT = 3, P_DONE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, cfg_valid, cfg_last, cfg_ready;
    logic [9:0]       cfg_data;
    logic [NREQ-1:0]  req_valid, req_ready, req_force;
    logic [NREQ*5-1:0]  req_bb1, req_bb2;
    logic [NREQ*10-1:0] req_tbuf;
    logic [23:0]      cvt_token;
    logic             cvt_send_batch, cvt_threads_terminated;
    logic [1:0]       grant_id;
    logic             busy, done, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int          m_phase, m_ptr, m_gid, m_err, m_waited;
    logic [23:0] m_tok;

    cvt_token_sched #(
        .NUM_REQ(NREQ),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_data               (cfg_data),
        .cfg_last               (cfg_last),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_bb1                (req_bb1),
        .req_bb2                (req_bb2),
        .req_tbuf               (req_tbuf),
        .req_force              (req_force),
        .cvt_token              (cvt_token),
        .cvt_send_batch         (cvt_send_batch),
        .cvt_threads_terminated (cvt_threads_terminated),
        .grant_id               (grant_id),
        .busy                   (busy),
        .done                   (done),
        .timeout_err            (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_ptr    = NREQ - 1;
        m_gid    = 0;
        m_err    = 0;
        m_waited = 0;
        m_tok    = '0;
    endtask

    task automatic zero_inputs();
        start = 0; cfg_valid = 0; cfg_last = 0; cfg_data = '0;
        req_valid = '0; cvt_send_batch = 0; cvt_threads_terminated = 0;
    endtask

    // Entered at posedge+1 with inputs already set; leaves at the next posedge+1.
    task automatic step();
        int w;
        int exp_rr;
        logic [23:0] tok_n;
        #2;
        w = -1;
        if (m_phase == P_ARB && !cvt_threads_terminated) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[c]) w = c;
            end
        end
        exp_rr = (w >= 0) ? (1 << w) : 0;
        check_eq("cfg_ready", cfg_ready, m_phase == P_CFG);
        check_eq("req_ready", req_ready, exp_rr);
        check_eq("busy", busy, m_phase != P_IDLE);
        check_eq("done", done, m_phase == P_DONE);

        tok_n = '0;
        case (m_phase)
            P_IDLE: if (start) m_phase = P_CFG;
            P_CFG: if (cfg_valid) begin
                tok_n = (24'(cfg_data) << 13) + 24'd5;
                if (cfg_last) m_phase = P_ARB;
            end
            P_ARB: begin
                if (cvt_threads_terminated) m_phase = P_DONE;
                else if (w >= 0) begin
                    tok_n = (24'(req_force[w]) << 23) + (24'(req_tbuf[w*10 +: 10]) << 13) +
                            (24'(req_bb2[w*5 +: 5]) << 8) + (24'(req_bb1[w*5 +: 5]) << 3) + 24'd6;
                    m_ptr    = w;
                    m_gid    = w;
                    m_waited = 0;
                    m_phase  = P_WAIT;
                end
            end
            P_WAIT: begin
                if (cvt_threads_terminated) m_phase = P_DONE;
                else if (cvt_send_batch) m_phase = P_ARB;
`ifdef CVT_TIMEOUT_EN
                else begin
                    m_waited++;
                    if (m_waited == TB_TIMEOUT) begin
                        m_err   = 1;
                        m_phase = P_ARB;
                    end
                end
`endif
            end
            default: m_phase = P_IDLE;
        endcase
        m_tok = tok_n;

        @(posedge clk);
        #1;
        check_eq("cvt_token", cvt_token, m_tok);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("timeout_err", timeout_err, m_err);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic apply_reset();
        zero_inputs();
        #2;
        rst = 1;
        #1;
        check_eq("rst_token", cvt_token, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gid", grant_id, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_cfg_ready", cfg_ready, 0);
        check_eq("rst_tmo", timeout_err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        start                  = ($urandom % 4) != 0;
        cfg_valid              = $urandom % 2;
        cfg_last               = ($urandom % 4) == 0;
        cfg_data               = 10'($urandom);
        req_valid              = NREQ'($urandom);
        req_bb1                = 20'($urandom);
        req_bb2                = 20'($urandom);
        req_tbuf               = 40'({$urandom, $urandom});
        req_force              = NREQ'($urandom);
        cvt_send_batch         = ($urandom % 5) == 0;
        cvt_threads_terminated = ($urandom % 30) == 0;
    endtask

    initial begin
        int pulses;
        logic [9:0] beats [3];
        beats[0] = 10'h001; beats[1] = 10'h155; beats[2] = 10'h3FF;

        zero_inputs();
        req_bb1 = '0; req_bb2 = '0; req_tbuf = '0; req_force = '0;
        rst = 1;
        @(posedge clk);
        #1;
        check_eq("reset_token", cvt_token, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_gid", grant_id, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Config stream of three beats
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1; cfg_data = beats[i]; cfg_last = (i == 2);
            step();
        end
        cfg_valid = 0; cfg_last = 0;

        // Round-robin with all requesters valid
        req_bb1   = 20'($urandom);
        req_bb2   = 20'($urandom);
        req_tbuf  = 40'({$urandom, $urandom});
        req_force = 4'b0000;
        req_bb1[9:5] = 5'd5; req_bb2[9:5] = 5'd9; req_tbuf[19:10] = 10'h02A; req_force[1] = 1'b1;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            check_eq("rr_order", grant_id, g % 4);
            if (g == 1) check_eq("rr_tok_req1", cvt_token, 24'h85492E);
            step();
            step();
            cvt_send_batch = 1;
            step();
            cvt_send_batch = 0;
        end

        // One token outstanding while send_batch is withheld
        req_valid = 4'b0011;
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            step();
            if (cvt_token[2]) pulses++;
        end
`ifndef CVT_TIMEOUT_EN
        check_eq("single_outstanding", pulses, 1);
`endif
        cvt_send_batch = 1;
        step();
        cvt_send_batch = 0;
        step();
        check_eq("regrant_after_batch", cvt_token[2], 1);

        // send_batch and threads_terminated together in WAIT
        cvt_send_batch = 1; cvt_threads_terminated = 1;
        step();
        cvt_send_batch = 0; cvt_threads_terminated = 0;
        step();
        step();
        check_eq("term_idle_busy", busy, 0);

        // Reset while a token is on the bus
        start = 1;
        step();
        start = 0; cfg_valid = 1; cfg_last = 1; cfg_data = 10'h0F0;
        step();
        cfg_valid = 0; cfg_last = 0; req_valid = 4'b1111;
        step();
        check_eq("pre_rst_tok_nz", cvt_token != 0, 1);
        apply_reset();
        start = 1;
        step();
        start = 0; cfg_valid = 1; cfg_last = 1;
        step();
        cfg_valid = 0; cfg_last = 0; req_valid = 4'b1111;
        step();
        check_eq("post_rst_first_grant", grant_id, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 500) == 0) apply_reset();
            drive_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
